// File: rtl/button_event_decoder.sv
// Turns the debounced button level into one-cycle press, release, short, long
// and auto-repeat events. It also provides a held level.
module button_event_decoder #(
    parameter int LONG_CYCLES   = 16,
    parameter int REPEAT_CYCLES = 8,
    parameter int CNT_W         = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic press_pulse,
    output logic release_pulse,
    output logic short_press,
    output logic long_press,
    output logic repeat_pulse,
    output logic held
);
    typedef enum logic [1:0] {IDLE, PRESSED, LONG} state_t;

    localparam bit             REP_EN    = (REPEAT_CYCLES != 0);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REP_EN ? REPEAT_CYCLES - 1 : 0);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             s1, s2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= btn_in;
            s2 <= s1;
        end
    end

    // Release is tested before any threshold, so a release always wins the cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            short_press   <= 1'b0;
            long_press    <= 1'b0;
            repeat_pulse  <= 1'b0;
            held          <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            short_press   <= 1'b0;
            long_press    <= 1'b0;
            repeat_pulse  <= 1'b0;
            case (state)
                IDLE: begin
                    if (s2) begin
                        state       <= PRESSED;
                        cnt         <= '0;
                        press_pulse <= 1'b1;
                        held        <= 1'b1;
                    end
                end
                PRESSED: begin
                    if (!s2) begin
                        state         <= IDLE;
                        cnt           <= '0;
                        release_pulse <= 1'b1;
                        short_press   <= 1'b1;
                        held          <= 1'b0;
                    end else if (cnt == LONG_LAST) begin
                        state      <= LONG;
                        cnt        <= '0;
                        long_press <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                LONG: begin
                    if (!s2) begin
                        state         <= IDLE;
                        cnt           <= '0;
                        release_pulse <= 1'b1;
                        held          <= 1'b0;
                    end else if (REP_EN && cnt == REP_LAST) begin
                        cnt          <= '0;
                        repeat_pulse <= 1'b1;
                    end else if (REP_EN) begin
                        // With auto-repeat off the count is frozen so it cannot wrap.
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    held  <= 1'b0;
                end
            endcase
        end
    end
endmodule
